pte_mem_responder: RTL and testbench

- Memory-side responder for page-walk PTE traffic: accepts one 32-bit PTE read or PTE A/D write-back request at a time from the page walker and issues it on the DRAM request/ack port.
- Returns read data, drives the walker's busy signal, and keeps a one-entry PTE buffer so repeated L1 reads skip DRAM.
- Sits between the MMU page walker and the DRAM arbiter.

---
 rtl/pte_mem_responder_pkg.sv | 20 ++
 rtl/pte_mem_responder_if.sv | 34 +++
 rtl/pte_buf_1entry.sv | 50 +++++
 rtl/pte_mem_responder.sv | 156 +++++++++++++++
 tb/tb_pte_mem_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pte_mem_responder_pkg.sv
// Shared definitions for the PTE memory responder: FSM state encoding,
// default abort timeout and the word-alignment helper.
package pte_mem_responder_pkg;

  typedef enum logic [1:0] {
    PTE_ST_IDLE = 2'd0,
    PTE_ST_RD   = 2'd1,
    PTE_ST_WR   = 2'd2,
    PTE_ST_DONE = 2'd3
  } pte_state_t;

  localparam int PTE_TIMEOUT_DEFAULT = 1024;
  localparam logic [31:0] PTE_WORD_MASK = 32'hFFFF_FFFC;

  // PTEs are 32-bit words; byte offset bits are forced to zero.
  function automatic logic [31:0] pte_word_addr(input logic [31:0] addr);
    return addr & PTE_WORD_MASK;
  endfunction

endpackage

// File: rtl/pte_mem_responder_if.sv
// Walker-side and DRAM-side signal bundle of the PTE memory responder.
// slave = responder view, master = walker/DRAM (testbench) view.
interface pte_mem_responder_if;

  logic        w_pte_req;
  logic        w_pte_we;
  logic [31:0] w_pte_addr;
  logic [31:0] w_pte_wdata;
  logic        w_tlb_flush;
  logic        w_pte_busy;
  logic [31:0] w_pte_rdata;
  logic        w_pte_err;
  logic        w_mem_req;
  logic        w_mem_we;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_ack;
  logic [31:0] w_mem_rdata;

  modport slave (
    input  w_pte_req, w_pte_we, w_pte_addr, w_pte_wdata, w_tlb_flush,
    input  w_mem_ack, w_mem_rdata,
    output w_pte_busy, w_pte_rdata, w_pte_err,
    output w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata
  );

  modport master (
    output w_pte_req, w_pte_we, w_pte_addr, w_pte_wdata, w_tlb_flush,
    output w_mem_ack, w_mem_rdata,
    input  w_pte_busy, w_pte_rdata, w_pte_err,
    input  w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata
  );

endinterface

// File: rtl/pte_buf_1entry.sv
// One-entry PTE buffer: word-address tag, data and valid bit.
// Fill takes precedence over write-update; flush always wins on valid.
module pte_buf_1entry (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] rd_data,
  input  logic        fill_en,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        flush
);

  logic        valid_reg;
  logic [31:0] tag_reg;
  logic [31:0] data_reg;

  // Tag/data storage: fill replaces the entry; a write-back only refreshes
  // data of an entry already holding the same word (no write-allocate).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg  <= '0;
      data_reg <= '0;
    end else if (fill_en) begin
      tag_reg  <= fill_addr;
      data_reg <= fill_data;
    end else if (wr_en && valid_reg && (tag_reg == wr_addr)) begin
      data_reg <= wr_data;
    end
  end

  // Valid bit: a flush in the same cycle as a fill leaves the entry invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
    end
  end

  assign hit     = valid_reg && (tag_reg == lookup_addr);
  assign rd_data = data_reg;

endmodule

// File: rtl/pte_mem_responder.sv
// PTE memory responder: serialises walker PTE reads/write-backs onto the
// DRAM request/ack port, with a one-entry buffer short-circuiting repeated
// reads and a timeout that aborts a request DRAM never acknowledges.
module pte_mem_responder
  import pte_mem_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PTE_TIMEOUT_DEFAULT,
  parameter int TOUT_WIDTH     = 11
) (
  input logic                clk,
  input logic                rst,
  pte_mem_responder_if.slave bus
);

  localparam logic [TOUT_WIDTH-1:0] TOUT_LAST = TOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TOUT_WIDTH-1:0] TOUT_ONE  = TOUT_WIDTH'(1);

  pte_state_t            state_reg, state_next;
  logic                  busy_reg, busy_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  mem_req_reg, mem_req_next;
  logic                  mem_we_reg, mem_we_next;
  logic [31:0]           mem_addr_reg, mem_addr_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;
  logic [TOUT_WIDTH-1:0] tout_reg, tout_next;

  logic [31:0] req_addr;
  logic        buf_hit;
  logic [31:0] buf_data;
  logic        buf_fill;
  logic        buf_wr;

  assign req_addr = pte_word_addr(bus.w_pte_addr);

  pte_buf_1entry u_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (req_addr),
    .hit         (buf_hit),
    .rd_data     (buf_data),
    .fill_en     (buf_fill),
    .fill_addr   (mem_addr_reg),
    .fill_data   (bus.w_mem_rdata),
    .wr_en       (buf_wr),
    .wr_addr     (mem_addr_reg),
    .wr_data     (mem_wdata_reg),
    .flush       (bus.w_tlb_flush)
  );

  // State and output registers; reset drops the DRAM request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= PTE_ST_IDLE;
      busy_reg      <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      tout_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      tout_reg      <= tout_next;
    end
  end

  // Next-state and output decode. Requests are only accepted in IDLE, and
  // DRAM acks are only honoured in MEM_RD/MEM_WR, so strays have no effect.
  always_comb begin
    state_next     = state_reg;
    busy_next      = busy_reg;
    rdata_next     = rdata_reg;
    err_next       = 1'b0;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    tout_next      = '0;
    buf_fill       = 1'b0;
    buf_wr         = 1'b0;

    case (state_reg)
      PTE_ST_IDLE: begin
        busy_next = 1'b0;
        if (bus.w_pte_req) begin
          if (bus.w_pte_we) begin
            state_next     = PTE_ST_WR;
            busy_next      = 1'b1;
            mem_req_next   = 1'b1;
            mem_we_next    = 1'b1;
            mem_addr_next  = req_addr;
            mem_wdata_next = bus.w_pte_wdata;
          end else if (buf_hit) begin
            rdata_next = buf_data;
          end else begin
            state_next    = PTE_ST_RD;
            busy_next     = 1'b1;
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = req_addr;
          end
        end
      end

      PTE_ST_RD, PTE_ST_WR: begin
        if (bus.w_mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = PTE_ST_DONE;
          if (state_reg == PTE_ST_RD) begin
            rdata_next = bus.w_mem_rdata;
            buf_fill   = 1'b1;
          end else begin
            buf_wr = 1'b1;
          end
        end else if (tout_reg == TOUT_LAST) begin
          // Zero read data decodes as an invalid PTE, so the walker faults.
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          rdata_next   = '0;
          state_next   = PTE_ST_DONE;
        end else begin
          tout_next = tout_reg + TOUT_ONE;
        end
      end

      PTE_ST_DONE: begin
        busy_next  = 1'b0;
        state_next = PTE_ST_IDLE;
      end

      default: begin
        busy_next    = 1'b0;
        mem_req_next = 1'b0;
        state_next   = PTE_ST_IDLE;
      end
    endcase
  end

  assign bus.w_pte_busy  = busy_reg;
  assign bus.w_pte_rdata = rdata_reg;
  assign bus.w_pte_err   = err_reg;
  assign bus.w_mem_req   = mem_req_reg;
  assign bus.w_mem_we    = mem_we_reg;
  assign bus.w_mem_addr  = mem_addr_reg;
  assign bus.w_mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_pte_mem_responder.sv
// Directed self-checking bench for pte_mem_responder.
module tb_pte_mem_responder;

  localparam int TIMEOUT_CYCLES = 1024;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pte_mem_responder_if bus ();

  pte_mem_responder #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TOUT_WIDTH     (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle walker request strobe; returns just after the sampling edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.w_pte_req   = 1'b1;
    bus.w_pte_we    = we;
    bus.w_pte_addr  = addr;
    bus.w_pte_wdata = wdata;
    step();
    bus.w_pte_req   = 1'b0;
    bus.w_pte_we    = 1'b0;
    $display("txn %s addr=%h wdata=%h", we ? "write" : "read ", addr, wdata);
  endtask

  // One-cycle DRAM ack, optional flush in the same cycle.
  task automatic mem_ack(input logic [31:0] rdata, input logic flush);
    bus.w_mem_ack   = 1'b1;
    bus.w_mem_rdata = rdata;
    bus.w_tlb_flush = flush;
    step();
    bus.w_mem_ack   = 1'b0;
    bus.w_tlb_flush = 1'b0;
    $display("txn ack  rdata=%h flush=%0d", rdata, flush);
  endtask

  int busy_cnt;
  int req_cnt;
  int guard;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.w_pte_req   = 1'b0;
    bus.w_pte_we    = 1'b0;
    bus.w_pte_addr  = '0;
    bus.w_pte_wdata = '0;
    bus.w_tlb_flush = 1'b0;
    bus.w_mem_ack   = 1'b0;
    bus.w_mem_rdata = '0;
    step();
    step();

    // Reset state
    check("rst_busy",  32'(bus.w_pte_busy), 32'd0);
    check("rst_rdata", bus.w_pte_rdata,     32'd0);
    check("rst_err",   32'(bus.w_pte_err),  32'd0);
    check("rst_req",   32'(bus.w_mem_req),  32'd0);
    check("rst_we",    32'(bus.w_mem_we),   32'd0);
    check("rst_addr",  bus.w_mem_addr,      32'd0);
    check("rst_wdata", bus.w_mem_wdata,     32'd0);
    rst = 1'b0;
    step();

    // Cold read: 4 cycles of request without ack, ack in the 5th, then DONE
    issue(1'b0, 32'h8000_1004, 32'h0);
    check("cold_req",  32'(bus.w_mem_req), 32'd1);
    check("cold_we",   32'(bus.w_mem_we),  32'd0);
    check("cold_addr", bus.w_mem_addr,     32'h8000_1004);
    busy_cnt = bus.w_pte_busy ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.w_pte_busy) busy_cnt++;
    end
    mem_ack(32'h2000_0C01, 1'b0);
    guard = 0;
    while (bus.w_pte_busy && guard < 8) begin
      busy_cnt++;
      step();
      guard++;
    end
    check("cold_busy_cycles", 32'(busy_cnt), 32'd6);
    check("cold_rdata", bus.w_pte_rdata, 32'h2000_0C01);
    check("cold_req_low", 32'(bus.w_mem_req), 32'd0);

    // Repeat read, different byte offset in same word: buffer hit
    issue(1'b0, 32'h8000_1006, 32'h0);
    check("hit_rdata", bus.w_pte_rdata,     32'h2000_0C01);
    check("hit_req",   32'(bus.w_mem_req),  32'd0);
    check("hit_busy",  32'(bus.w_pte_busy), 32'd0);
    step();
    check("hit_busy2", 32'(bus.w_pte_busy), 32'd0);

    // Write-back updates the buffered entry; following read hits
    issue(1'b1, 32'h8000_1004, 32'h2000_0CC1);
    check("wr_req",   32'(bus.w_mem_req), 32'd1);
    check("wr_we",    32'(bus.w_mem_we),  32'd1);
    check("wr_addr",  bus.w_mem_addr,     32'h8000_1004);
    check("wr_wdata", bus.w_mem_wdata,    32'h2000_0CC1);
    mem_ack(32'h0, 1'b0);
    check("wr_done_busy", 32'(bus.w_pte_busy), 32'd1);
    step();
    check("wr_idle_busy", 32'(bus.w_pte_busy), 32'd0);
    issue(1'b0, 32'h8000_1004, 32'h0);
    check("wr_hit_rdata", bus.w_pte_rdata,    32'h2000_0CC1);
    check("wr_hit_req",   32'(bus.w_mem_req), 32'd0);

    // Timeout: request held for TIMEOUT_CYCLES cycles, then aborted
    issue(1'b0, 32'h9000_0000, 32'h0);
    req_cnt = 0;
    guard = 0;
    while (bus.w_mem_req && guard < TIMEOUT_CYCLES + 50) begin
      req_cnt++;
      step();
      guard++;
    end
    check("tout_req_cycles", 32'(req_cnt), 32'(TIMEOUT_CYCLES));
    check("tout_err",   32'(bus.w_pte_err),  32'd1);
    check("tout_rdata", bus.w_pte_rdata,     32'd0);
    step();
    check("tout_err_pulse", 32'(bus.w_pte_err),  32'd0);
    check("tout_busy",      32'(bus.w_pte_busy), 32'd0);
    mem_ack(32'hDEAD_BEEF, 1'b0);
    check("late_ack_rdata", bus.w_pte_rdata,     32'd0);
    check("late_ack_busy",  32'(bus.w_pte_busy), 32'd0);
    check("late_ack_req",   32'(bus.w_mem_req),  32'd0);

    // Flush coincident with a read fill: data returned, entry left invalid
    issue(1'b0, 32'hA000_0040, 32'h0);
    step();
    mem_ack(32'h1111_2223, 1'b1);
    check("flfill_rdata", bus.w_pte_rdata, 32'h1111_2223);
    step();
    issue(1'b0, 32'hA000_0040, 32'h0);
    check("flfill_miss_req", 32'(bus.w_mem_req), 32'd1);
    mem_ack(32'h1111_2224, 1'b0);
    step();
    check("refill_rdata", bus.w_pte_rdata, 32'h1111_2224);

    // Flush coincident with an IDLE hit: hit data returned, then invalid
    bus.w_tlb_flush = 1'b1;
    issue(1'b0, 32'hA000_0041, 32'h0);
    bus.w_tlb_flush = 1'b0;
    check("flhit_rdata", bus.w_pte_rdata,    32'h1111_2224);
    check("flhit_req",   32'(bus.w_mem_req), 32'd0);
    issue(1'b0, 32'hA000_0040, 32'h0);
    check("flhit_miss_req", 32'(bus.w_mem_req), 32'd1);
    mem_ack(32'h3333_0001, 1'b0);
    step();

    // Request while busy is ignored; reset mid MEM_WR clears outputs at once
    issue(1'b1, 32'h8000_3000, 32'h5555_AAAA);
    issue(1'b0, 32'h8000_1004, 32'h0);
    check("busy_req_addr",  bus.w_mem_addr,     32'h8000_3000);
    check("busy_req_we",    32'(bus.w_mem_we),  32'd1);
    check("busy_req_wdata", bus.w_mem_wdata,    32'h5555_AAAA);
    check("busy_req_rdata", bus.w_pte_rdata,    32'h3333_0001);
    rst = 1'b1;
    #1;
    check("arst_req",   32'(bus.w_mem_req),  32'd0);
    check("arst_busy",  32'(bus.w_pte_busy), 32'd0);
    check("arst_we",    32'(bus.w_mem_we),   32'd0);
    check("arst_addr",  bus.w_mem_addr,      32'd0);
    check("arst_rdata", bus.w_pte_rdata,     32'd0);
    step();
    rst = 1'b0;
    step();
    mem_ack(32'hCAFE_0001, 1'b0);
    check("post_rst_ack_rdata", bus.w_pte_rdata,    32'd0);
    check("post_rst_ack_busy",  32'(bus.w_pte_busy), 32'd0);
    check("post_rst_ack_req",   32'(bus.w_mem_req),  32'd0);

    // Buffer is invalid after reset: a previously buffered word misses
    issue(1'b0, 32'hA000_0040, 32'h0);
    check("post_rst_miss_req", 32'(bus.w_mem_req), 32'd1);
    mem_ack(32'h3333_0002, 1'b0);
    step();
    check("post_rst_rdata", bus.w_pte_rdata,     32'h3333_0002);
    check("post_rst_busy",  32'(bus.w_pte_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
